// File: rtl/mips_pkg.sv
// Shared constants for the 5-stage MIPS core: bubble instruction, reset PC,
// opcodes and instruction field positions.
package mips_pkg;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [5:0]  OP_J          = 6'b000010;
  localparam logic [5:0]  OP_BEQ        = 6'b000100;
  localparam int          OPCODE_MSB    = 31;
  localparam int          OPCODE_LSB    = 26;
  localparam int          JIDX_WIDTH    = 26;

  // Pseudo-direct jump: top nibble of the jump's own PC+4, index, word align.
  function automatic logic [31:0] jump_addr(input logic [31:0] pc4,
                                            input logic [JIDX_WIDTH-1:0] idx);
    return {pc4[31:28], idx, 2'b00};
  endfunction
endpackage

// File: rtl/pc_reg.sv
// Program counter register: synchronous reset, hold enable, parallel load.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hold,
  input  logic [31:0] i_load_val,
  output logic [31:0] o_pc
);
  logic [31:0] r_pc;

  always_ff @(posedge clk) begin
    if (rst)          r_pc <= RESET_PC;
    else if (!i_hold) r_pc <= i_load_val;
  end

  assign o_pc = r_pc;
endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch plus IF/ID pipeline register: next-PC selection,
// load-use stall hold, branch/jump flush and a saturating stall counter.
module if_id_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Stall_Data_Hazard,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_target,
  input  logic                  jump,
  input  logic [JIDX_WIDTH-1:0] jump_index,
  output logic [31:0]           imem_addr,
  input  logic [31:0]           imem_data,
  output logic [31:0]           pc,
  output logic [31:0]           if_id_instr,
  output logic [31:0]           if_id_pc4,
  output logic                  if_id_valid,
  output logic [15:0]           stall_count
);
  logic [31:0] w_pc;
  logic [31:0] w_pc4;
  logic [31:0] w_next_pc;
  logic        w_jump_go;
  logic        w_flush;
  logic        w_hold;

  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic [15:0] r_stall_cnt;

  assign w_pc4 = w_pc + 32'd4;
  // A stalled jump waits in ID; a taken branch overrides both jump and stall.
  assign w_jump_go = jump && !Stall_Data_Hazard;
  assign w_flush   = branch_taken || w_jump_go;
  assign w_hold    = Stall_Data_Hazard && !branch_taken;

  always_comb begin
    w_next_pc = w_pc4;
    if (branch_taken)   w_next_pc = branch_target;
    else if (w_jump_go) w_next_pc = jump_addr(r_pc4, jump_index);
  end

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .i_hold     (w_hold),
    .i_load_val (w_next_pc),
    .o_pc       (w_pc)
  );

  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= 32'd0;
      r_valid <= 1'b0;
    end else if (!Stall_Data_Hazard) begin
      r_instr <= imem_data;
      r_pc4   <= w_pc4;
      r_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= 16'd0;
    else if (w_hold && r_stall_cnt != 16'hFFFF)
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign imem_addr   = w_pc;
  assign pc          = w_pc;
  assign if_id_instr = r_instr;
  assign if_id_pc4   = r_pc4;
  assign if_id_valid = r_valid;
  assign stall_count = r_stall_cnt;
endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: directed plan scenarios then random
// stimulus, checked against a behavioural fetch model.
module tb_if_id_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br;
  logic [31:0] br_tgt;
  logic        jmp;
  logic [25:0] jidx;
  logic [31:0] imem_addr, imem_data, pc, if_id_instr, if_id_pc4;
  logic        if_id_valid;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  // Instruction memory: word at address A is A + 0x1000_0000.
  assign imem_data = imem_addr + 32'h1000_0000;

  if_id_stage dut (
    .clk(clk), .rst(rst), .Stall_Data_Hazard(stall),
    .branch_taken(br), .branch_target(br_tgt),
    .jump(jmp), .jump_index(jidx),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .stall_count(stall_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Architectural state of the fetch model
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [15:0] m_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h1000_0000;
  endfunction

  task automatic bubble();
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
  endtask

  task automatic step(input logic r, input logic s, input logic b,
                      input logic [31:0] t, input logic j, input logic [25:0] ji);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; br = b; br_tgt = t; jmp = j; jidx = ji;
    if (r) begin
      m_pc = 32'h0; m_cnt = 16'h0; bubble();
    end else if (b) begin
      m_pc = t; bubble();
    end else if (j && !s) begin
      m_pc = {m_pc4[31:28], 4'h0, 24'h0} | ({6'h0, ji} << 2); bubble();
    end else if (s) begin
      if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else begin
      m_instr = mem_word(m_pc);
      m_pc    = m_pc + 32'd4;
      m_pc4   = m_pc;
      m_valid = 1'b1;
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
  endtask

  // Monitor: registered outputs are compared just after every active edge.
  always @(posedge clk) begin
    exp_t e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.pc = pc; a.instr = if_id_instr; a.pc4 = if_id_pc4;
      a.valid = if_id_valid; a.cnt = stall_count;
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL state @%0t: got pc=%h instr=%h pc4=%h valid=%b cnt=%h, want pc=%h instr=%h pc4=%h valid=%b cnt=%h",
                 $time, a.pc, a.instr, a.pc4, a.valid, a.cnt,
                 e.pc, e.instr, e.pc4, e.valid, e.cnt);
      end
      n_chk++;
      if (imem_addr !== e.pc) begin
        n_fail++;
        $display("FAIL imem_addr @%0t: got %h want %h", $time, imem_addr, e.pc);
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; br = 1'b0; br_tgt = 32'h0; jmp = 1'b0; jidx = 26'h0;
    m_pc = 32'h0; m_cnt = 16'h0; bubble();

    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 26'h3);
    run(2);                                   // pc 0 -> 4 -> 8
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    run(2);                                   // pc 12, then 16
    step(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 26'h0);      // branch beats stall
    step(1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 26'h5); // branch beats jump
    run(1);                                   // if_id_pc4 = 8000_0004
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 26'h10);       // stalled jump holds
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h10);       // pc = 8000_0040
    run(1);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0);
    run(2);                                   // wrap to 0, if_id_pc4 = 0

    for (int i = 0; i < 600; i++) begin
      logic r, s, b, j;
      r = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 9) == 0);
      j = ($urandom_range(0, 6) == 0);
      step(r, s, b, $urandom & 32'hFFFF_FFFC, j, 26'($urandom));
    end

    for (int i = 0; i < 65540; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);        // stays at FFFF
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);        // reset mid-stall
    run(3);

    @(negedge clk);
    stall = 1'b0; br = 1'b0; jmp = 1'b0;
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expected entries never checked, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS core.
- Owns the PC and selects next-PC: sequential, branch, or jump. Drives the instruction-memory address and latches the fetched instruction.
- Feeds the ID stage, whose opcode field (if_id_instr[31:26]) goes to the main control decoder.
- Honours the load-use stall signal that also zeroes the control outputs. Flushes on taken branch or jump.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble instruction (sll $0,$0,0; decodes as R-type with harmless write to $0).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- Stall_Data_Hazard  input  1  load-use stall from hazard unit; freezes PC and IF/ID.
- branch_taken  input  1  branch resolved taken (beq and ALU zero), from EX/MEM.
- branch_target  input  32  branch target address.
- jump  input  1  jump decoded in ID.
- jump_index  input  26  instr[25:0] of the jump in ID.
- imem_addr  output  32  instruction-memory address; equals pc.
- imem_data  input  32  instruction word, combinational read of imem_addr.
- pc  output  32  current PC.
- if_id_instr  output  32  registered instruction to ID.
- if_id_pc4  output  32  registered PC+4 of that instruction.
- if_id_valid  output  1  1 = real instruction, 0 = bubble.
- stall_count  output  16  saturating count of stalled cycles (performance counter).

Behaviour:
- Reset (rst=1 at edge), highest priority:
  - pc<=RESET_PC, if_id_instr<=NOP_INSTR, if_id_pc4<=0, if_id_valid<=0, stall_count<=0.
  - Reset mid-stall or mid-redirect discards all pending state.
- pc4 = pc + 32'd4, 32-bit wrap (32'hFFFF_FFFC + 4 = 0).
- jump_target = {if_id_pc4[31:28], jump_index, 2'b00}.
- Per-edge priority when not in reset:
  1. branch_taken=1: pc<=branch_target; IF/ID <= NOP_INSTR, pc4 0, valid 0. Overrides jump and stall, because the instruction in ID is wrong-path.
  2. else jump=1 and Stall_Data_Hazard=0: pc<=jump_target; IF/ID flushed as above (one-cycle bubble).
  3. else Stall_Data_Hazard=1: pc, if_id_instr, if_id_pc4, if_id_valid all hold; stall_count increments unless at 16'hFFFF (saturates).
  4. else: pc<=pc4; if_id_instr<=imem_data; if_id_pc4<=pc4; if_id_valid<=1.
- jump with stall asserted is ignored that cycle. The jump stays in ID and takes effect on the first unstalled cycle.
- Latency:
  - Instruction at address A appears on if_id_instr one cycle after pc=A.
  - Taken branch or jump costs the bubbles described above; no extra cycle beyond the redirect edge.
- stall_count changes only on reset and stall cycles. Branch-overridden stall cycles are not counted.
- imem_addr is a combinational copy of pc. There is no other combinational path to the outputs.
- All outputs are registers, except imem_addr.

Decomposition:
- Shared package mips_pkg: NOP_INSTR, RESET_PC default, OP_J=6'b000010, OP_BEQ=6'b000100, instruction field slice constants (OPCODE_MSB=31, OPCODE_LSB=26, JIDX_WIDTH=26).
- One natural sub-module, pc_reg: PC register with reset, hold enable and load value. if_id_stage instantiates it and owns the next-PC mux, the IF/ID register and the stall counter.

Test Plan:
- Reset then run, imem returns A+32'h1000_0000 for address A. Required: after reset pc=0, valid=0. Next edge: if_id_instr=32'h1000_0000, pc4=4, pc=4, valid=1.
- Stall_Data_Hazard=1 for 2 cycles at pc=8. Required: pc stays 8, IF/ID unchanged, stall_count 0->2. After release, pc=12 on the next edge.
- branch_taken=1 with branch_target=32'h40 at pc=16, simultaneous with stall=1. Required: pc=32'h40, if_id_instr=0, valid=0, stall_count unchanged.
- jump=1, jump_index=26'h10, if_id_pc4=32'h8000_0004. Required: pc=32'h8000_0040, IF/ID flushed, valid=0. Same input with stall=1 must hold pc.
- Wrap: pc=32'hFFFF_FFFC, no stall. Required: pc=0, if_id_pc4=0.
- Saturation: stall held for 65540 cycles. Required: stall_count=16'hFFFF. Assert rst mid-stall. Required: next edge counter 0, pc=RESET_PC, valid=0.
